// File: rtl/spart_pkg.sv
// Shared definitions for the SPART: bus register map, FSM state types, divisor floor.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package spart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DBL    = 2'b10;
    localparam logic [1:0] ADDR_DBH    = 2'b11;

    // Below two cycles per bit the RX half-bit count would reach zero.
    localparam logic [15:0] DIV_MIN = 16'd2;

    typedef enum logic {
        TX_IDLE,
        TX_SHIFT
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

endpackage

// File: rtl/spart_rx.sv
// 8N1 receiver: rxd synchroniser, RX FSM, receive buffer, rda/ferr flags.
// Latency: rda rises SYNC_STAGES+1 cycles after the stop bit's mid-point on rxd.
// Backpressure: none; an unread byte is overwritten by the next good frame.
// Ports: rxd_i async serial in; div_i clamped divisor; clr_rda_i/clr_ferr_i read-side clears;
//        rx_buf_o last good byte; rda_o byte available; ferr_o stop bit seen low.
module spart_rx
    import spart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rxd_i,
    input  logic [15:0] div_i,
    input  logic        clr_rda_i,
    input  logic        clr_ferr_i,
    output logic [7:0]  rx_buf_o,
    output logic        rda_o,
    output logic        ferr_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    rx_state_t              state_q, state_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             buf_q, buf_d;
    logic                   rda_q, rda_d;
    logic                   ferr_q, ferr_d;
    logic                   expire;

    assign rxs    = sync_q[SYNC_STAGES-1];
    assign expire = (cnt_q == 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '1;
            state_q <= RX_IDLE;
            cnt_q   <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            buf_q   <= 8'd0;
            rda_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rxd_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            buf_q   <= buf_d;
            rda_q   <= rda_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        buf_d   = buf_q;
        rda_d   = rda_q;
        ferr_d  = ferr_q;

        // Clears first so a completing frame in the same cycle wins.
        if (clr_rda_i)  rda_d  = 1'b0;
        if (clr_ferr_i) ferr_d = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (!rxs) begin
                    cnt_d   = {1'b0, div_i[15:1]};
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (expire) begin
                    if (rxs) begin
                        state_d = RX_IDLE;
                    end else begin
                        cnt_d   = div_i;
                        bit_d   = 3'd0;
                        state_d = RX_DATA;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            RX_DATA: begin
                if (expire) begin
                    shift_d = {rxs, shift_q[7:1]};
                    cnt_d   = div_i;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            RX_STOP: begin
                if (expire) begin
                    if (rxs) begin
                        buf_d = shift_q;
                        rda_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_buf_o = buf_q;
    assign rda_o    = rda_q;
    assign ferr_o   = ferr_q;

endmodule

// File: rtl/spart.sv
// SPART top: bus decode, divisor registers, databus tristate, 8N1 transmitter, RX instance.
// Latency: reads combinational same cycle; txd start bit the cycle after a data write.
// Backpressure: tbr=0 while a frame is shifting; data writes then are dropped.
// Ports: iocs/iorw/ioaddr bus cycle; databus bidirectional data; rda/tbr handshakes;
//        txd serial out (idle high); rxd async serial in.
module spart
    import spart_pkg::*;
#(
    parameter logic [15:0] DEFAULT_DIV = 16'd10416,
    parameter int          SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    logic        wr_en, rd_en;
    logic [15:0] div_q, div_d;
    logic [15:0] eff_div;
    tx_state_t   tx_state_q, tx_state_d;
    logic [9:0]  tx_sh_q, tx_sh_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  rd_dat;
    logic [7:0]  rx_buf;
    logic        ferr;

    assign wr_en   = iocs & ~iorw;
    assign rd_en   = iocs & iorw;
    assign eff_div = clamp_div(div_q);

    spart_rx #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd_i      (rxd),
        .div_i      (eff_div),
        .clr_rda_i  (rd_en && (ioaddr == ADDR_DATA)),
        .clr_ferr_i (rd_en && (ioaddr == ADDR_STATUS)),
        .rx_buf_o   (rx_buf),
        .rda_o      (rda),
        .ferr_o     (ferr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= DEFAULT_DIV;
            tx_state_q <= TX_IDLE;
            tx_sh_q    <= '1;
            tx_cnt_q   <= 16'd0;
            tx_bit_q   <= 4'd0;
        end else begin
            div_q      <= div_d;
            tx_state_q <= tx_state_d;
            tx_sh_q    <= tx_sh_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
        end
    end

    always_comb begin
        div_d      = div_q;
        tx_state_d = tx_state_q;
        tx_sh_d    = tx_sh_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;

        if (wr_en && (ioaddr == ADDR_DBL)) div_d[7:0]  = databus;
        if (wr_en && (ioaddr == ADDR_DBH)) div_d[15:8] = databus;

        case (tx_state_q)
            TX_IDLE: begin
                if (wr_en && (ioaddr == ADDR_DATA)) begin
                    tx_sh_d    = {1'b1, databus, 1'b0};
                    tx_cnt_d   = eff_div;
                    tx_bit_d   = 4'd0;
                    tx_state_d = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                // Divisor is re-read at every bit boundary, so a mid-frame
                // change takes effect from the next bit.
                if (tx_cnt_q == 16'd1) begin
                    if (tx_bit_q == 4'd9) begin
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_sh_d  = {1'b1, tx_sh_q[9:1]};
                        tx_bit_d = tx_bit_q + 4'd1;
                        tx_cnt_d = eff_div;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign tbr = (tx_state_q == TX_IDLE);
    assign txd = (tx_state_q == TX_SHIFT) ? tx_sh_q[0] : 1'b1;

    always_comb begin
        rd_dat = 8'h00;
        case (ioaddr)
            ADDR_DATA:   rd_dat = rx_buf;
            ADDR_STATUS: rd_dat = {5'b0, ferr, tbr, rda};
            ADDR_DBL:    rd_dat = div_q[7:0];
            ADDR_DBH:    rd_dat = div_q[15:8];
            default:     rd_dat = 8'h00;
        endcase
    end

    assign databus = rd_en ? rd_dat : 8'hzz;

endmodule

// File: tb/tb_spart.sv
module tb_spart;
    import spart_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iocs = 1'b0;
    logic       iorw = 1'b0;
    logic [1:0] ioaddr = 2'b00;
    wire  [7:0] databus;
    logic       rda, tbr, txd;
    wire        rxd;
    logic       rxd_drv = 1'b1;
    logic       loop_en = 1'b0;
    logic       tb_drv = 1'b0;
    logic [7:0] tb_dat = 8'h00;

    assign databus = tb_drv ? tb_dat : 8'hzz;
    assign rxd     = loop_en ? txd : rxd_drv;

    always #5 clk = ~clk;

    spart dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus),
        .rda     (rda),
        .tbr     (tbr),
        .txd     (txd),
        .rxd     (rxd)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    int         cur_div = 10416;
    bit         mon_en  = 1'b0;

    typedef struct {
        logic       wr;
        logic [1:0] addr;
        logic [7:0] wdat;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; tb_dat = d; tb_drv = 1'b1;
        @(posedge clk);
        #1;
        iocs = 1'b0; tb_drv = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        #1;
        d = databus;
        @(posedge clk);
        #1;
        iocs = 1'b0; iorw = 1'b0;
    endtask

    task automatic set_div(input int d);
        logic [15:0] dv;
        dv = d[15:0];
        bus_write(ADDR_DBL, dv[7:0]);
        bus_write(ADDR_DBH, dv[15:8]);
        cur_div = (d < 2) ? 2 : d;
    endtask

    task automatic send_tx(input logic [7:0] b);
        bus_write(ADDR_DATA, b);
        txq.push_back(b);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        @(posedge clk);
        #1;
        rxd_drv = 1'b0;
        repeat (cur_div) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            repeat (cur_div) @(posedge clk);
            #1;
        end
        rxd_drv = stop;
        repeat (cur_div) @(posedge clk);
        #1;
        rxd_drv = 1'b1;
        if (stop) rxq.push_back(b);
    endtask

    task automatic wait_rda(input int budget);
        int n = 0;
        while (rda !== 1'b1 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rda_wait", rda, 1);
    endtask

    task automatic wait_tbr(input int budget);
        int n = 0;
        while (tbr !== 1'b1 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("tbr_wait", tbr, 1);
    endtask

    // Reads the data register; the model's rx_buf is the newest byte delivered.
    task automatic rx_check(input string name, output logic [7:0] got);
        logic [7:0] exp;
        bus_read(ADDR_DATA, got);
        exp = (rxq.size() > 0) ? rxq[$] : 8'hxx;
        check(name, got, exp);
        rxq.delete();
    endtask

    task automatic echo(input logic [7:0] b);
        logic [7:0] got;
        send_tx(b);
        rxq.push_back(b);
        wait_rda(12 * cur_div + 50);
        rx_check("echo_rx", got);
        wait_tbr(12 * cur_div + 50);
        send_tx(got);
        rxq.push_back(got);
        wait_rda(12 * cur_div + 50);
        rx_check("echo_back", got);
        wait_tbr(12 * cur_div + 50);
        repeat (10) @(posedge clk);
        #1;
    endtask

    // TX scoreboard: decode each frame on txd at mid-bit and pop the expected byte.
    initial begin
        forever begin
            @(negedge txd);
            if (mon_en) begin
                int         d;
                logic [7:0] b;
                logic       s0, s9;
                d = cur_div;
                repeat (d / 2) @(posedge clk);
                #1;
                s0 = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (d) @(posedge clk);
                    #1;
                    b[i] = txd;
                end
                repeat (d) @(posedge clk);
                #1;
                s9 = txd;
                check("tx_start", s0, 0);
                check("tx_stop", s9, 1);
                if (txq.size() == 0) check("tx_unexpected", b, 8'hxx);
                else check("tx_byte", b, txq.pop_front());
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete (%0d tests, %0d failed)", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got;
        logic [9:0] fr;
        int         errs[10];

        vecs[0] = '{1'b0, ADDR_DBL,    8'h00, 8'hB0};
        vecs[1] = '{1'b0, ADDR_DBH,    8'h00, 8'h28};
        vecs[2] = '{1'b0, ADDR_STATUS, 8'h00, 8'h02};
        vecs[3] = '{1'b0, ADDR_DATA,   8'h00, 8'h00};
        vecs[4] = '{1'b1, ADDR_DBL,    8'h10, 8'h00};
        vecs[5] = '{1'b1, ADDR_DBH,    8'h00, 8'h00};
        vecs[6] = '{1'b0, ADDR_DBL,    8'h00, 8'h10};
        vecs[7] = '{1'b0, ADDR_DBH,    8'h00, 8'h00};
        vecs[8] = '{1'b1, ADDR_STATUS, 8'hFF, 8'h00};
        vecs[9] = '{1'b0, ADDR_STATUS, 8'h00, 8'h02};

        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_tbr", tbr, 1);
        check("reset_rda", rda, 0);
        check("reset_txd", txd, 1);

        // Register map, reset divisor, divisor programming, ignored status write.
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].wdat);
            end else begin
                bus_read(vecs[i].addr, got);
                check($sformatf("vec%0d", i), got, vecs[i].exp);
            end
        end
        cur_div = 16;

        // Exact TX waveform at DIV=16.
        fr = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10; i++) errs[i] = 0;
        bus_write(ADDR_DATA, 8'hA5);
        for (int c = 0; c < 160; c++) begin
            if (txd !== fr[c / 16]) errs[c / 16]++;
            if (c == 159) check("tbr_busy_159", tbr, 0);
            @(posedge clk);
            #1;
        end
        check("tbr_at_160", tbr, 1);
        check("txd_idle_160", txd, 1);
        for (int i = 0; i < 10; i++) check($sformatf("tx_bit%0d_cycles", i), errs[i], 0);
        repeat (5) @(posedge clk);
        #1;
        mon_en = 1'b1;

        // RX good frame.
        send_rx(8'h3C, 1'b1);
        check("rx_rda_set", rda, 1);
        rx_check("rx_3c", got);
        check("rx_rda_clr", rda, 0);

        // Start-bit glitch, then a framing error observed while TX is busy.
        @(posedge clk);
        #1;
        rxd_drv = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rxd_drv = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("glitch_no_rda", rda, 0);
        bus_read(ADDR_STATUS, got);
        check("glitch_status", got, 8'h02);
        send_rx(8'h81, 1'b0);
        check("ferr_no_rda", rda, 0);
        send_tx(8'h96);
        bus_read(ADDR_STATUS, got);
        check("ferr_status", got, 8'h04);
        bus_read(ADDR_STATUS, got);
        check("ferr_cleared", got, 8'h00);
        wait_tbr(200);
        repeat (20) @(posedge clk);
        #1;

        // Write while busy is dropped; RX overrun keeps the newest byte.
        send_tx(8'h11);
        repeat (5) @(posedge clk);
        #1;
        bus_write(ADDR_DATA, 8'h22);
        wait_tbr(200);
        repeat (20) @(posedge clk);
        #1;
        check("tx_drop_q", txq.size(), 0);
        send_rx(8'h5A, 1'b1);
        send_rx(8'hC3, 1'b1);
        check("overrun_rda", rda, 1);
        rx_check("rx_overrun", got);

        // Loopback echo at a real baud divisor and at the clamped minimum.
        loop_en = 1'b1;
        set_div(1301);
        echo(8'h6B);
        set_div(1);
        bus_read(ADDR_DBL, got);
        check("div1_readback", got, 8'h01);
        echo(8'hE4);

        // Reset in the middle of a frame.
        mon_en = 1'b0;
        bus_write(ADDR_DATA, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_txd", txd, 0);
        check("pre_rst_tbr", tbr, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_txd", txd, 1);
        check("rst_tbr", tbr, 1);
        check("rst_rda", rda, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(ADDR_DBL, got);
        check("rst_div", got, 8'hB0);
        check("txq_empty", txq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
